mdu_iter: RTL

- Parametrised multiply/divide unit with architectural HI/LO registers, used by the execute stage.
- Replaces the vendor divider IP and free-standing HI/LO instance with an iterative radix-2 divider and a pipelined multiplier.
- Uses a valid/ready request handshake, a busy/done completion interface, and supports flush for exceptions and branch cancellation.
- Execute stage stalls on `busy`; HI/LO reads are combinational from the registers.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_div_core.sv | 104 ++++++++++
 rtl/mdu_iter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the iterative multiply/divide unit.
// Holds the request opcodes, the controller state enum and the default width.
package mdu_pkg;

  localparam int MDU_DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: restoring radix-2 divider working on operand magnitudes.
// The first quotient bit is produced on the start edge, so the last of the
// DATA_W iterations lands on the edge where `valid` is high. Signs and the
// divide-by-zero quotient are applied combinationally on the held result.
// Optional: MDU_EARLY_OUT_EN finishes immediately when |b| > |a| or b == 0.
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              abort,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              valid
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] a_mag, b_mag;
  logic              early;
  logic [DATA_W-1:0] rem_q, quo_q, div_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              active_q, neg_quo_q, neg_rem_q, zero_div_q;
  logic [DATA_W-1:0] step_rem, step_quo, step_div, next_rem, next_quo;
  logic [DATA_W:0]   partial, diff;

  assign a_mag = (signed_op && a[DATA_W-1]) ? -a : a;
  assign b_mag = (signed_op && b[DATA_W-1]) ? -b : b;

`ifdef MDU_EARLY_OUT_EN
  assign early = (b_mag == '0) || (b_mag > a_mag);
`else
  assign early = 1'b0;
`endif

  // One restoring step; on start it works on freshly loaded magnitudes.
  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    step_div = div_q;
    if (start) begin
      step_rem = '0;
      step_quo = a_mag;
      step_div = b_mag;
    end
    partial = {step_rem, step_quo[DATA_W-1]};
    diff    = partial - {1'b0, step_div};
    if (!diff[DATA_W]) begin
      next_rem = diff[DATA_W-1:0];
      next_quo = {step_quo[DATA_W-2:0], 1'b1};
    end else begin
      next_rem = partial[DATA_W-1:0];
      next_quo = {step_quo[DATA_W-2:0], 1'b0};
    end
  end

  // Iteration registers: load on start, shift one bit per cycle while active.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      active_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
    end else if (abort) begin
      active_q <= 1'b0;
    end else if (start) begin
      neg_quo_q  <= signed_op && (a[DATA_W-1] ^ b[DATA_W-1]);
      neg_rem_q  <= signed_op && a[DATA_W-1];
      zero_div_q <= (b == '0);
      div_q      <= b_mag;
      if (early) begin
        rem_q    <= a_mag;
        quo_q    <= '0;
        active_q <= 1'b0;
      end else begin
        rem_q    <= next_rem;
        quo_q    <= next_quo;
        cnt_q    <= CNT_W'(1);
        active_q <= 1'b1;
      end
    end else if (active_q) begin
      rem_q <= next_rem;
      quo_q <= next_quo;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) active_q <= 1'b0;
    end
  end

  assign valid     = (active_q && (cnt_q == LAST)) || (start && early);
  assign quotient  = zero_div_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
  assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multiply/divide unit with architectural HI/LO registers.
// Multiplies commit MUL_LAT cycles after accept, divides DATA_W+1 cycles
// after accept (FIX cycle applies signs), MTHI/MTLO commit on accept.
// Optional: MDU_EARLY_OUT_EN lets trivial divides finish in 2 cycles.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int DATA_W  = MDU_DATA_W,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi_rdata,
  output logic [DATA_W-1:0] lo_rdata
);

  localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);

  mdu_state_t        state_q, state_d;
  logic              accept, div_start, div_valid;
  logic [DATA_W-1:0] hi_q, lo_q, hi_d, lo_d, div_quo, div_rem;
  logic              done_q, done_d;
  logic [2:0]        mul_cnt_q;
  logic [DATA_W-1:0] mul_a_q, mul_b_q, mul_a, mul_b;
  logic              mul_signed_q, mul_signed;
  logic [2*DATA_W-1:0] mul_ext_a, mul_ext_b, product;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign hi_rdata  = hi_q;
  assign lo_rdata  = lo_q;
  assign accept    = req_valid && req_ready && !flush;
  assign div_start = accept && ((req_op == OP_DIV) || (req_op == OP_DIVU));

  // Multiplier: operands straight from the request while idle (single-cycle
  // latency case), otherwise from the registered first pipeline stage.
  always_comb begin
    mul_a      = (state_q == ST_IDLE) ? req_src1 : mul_a_q;
    mul_b      = (state_q == ST_IDLE) ? req_src2 : mul_b_q;
    mul_signed = (state_q == ST_IDLE) ? (req_op == OP_MULT) : mul_signed_q;
    mul_ext_a  = mul_signed ? {{DATA_W{mul_a[DATA_W-1]}}, mul_a} : {{DATA_W{1'b0}}, mul_a};
    mul_ext_b  = mul_signed ? {{DATA_W{mul_b[DATA_W-1]}}, mul_b} : {{DATA_W{1'b0}}, mul_b};
    product    = mul_ext_a * mul_ext_b;
  end

  mdu_div_core #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .signed_op (req_op == OP_DIV),
    .a         (req_src1),
    .b         (req_src2),
    .abort     (flush),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  // Next state plus HI/LO commit decisions; flush cancels any pending write.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MULT, OP_MULTU: begin
              if (MUL_LAT == 1) begin
                {hi_d, lo_d} = product;
                done_d       = 1'b1;
              end else begin
                state_d = ST_MUL;
              end
            end
            OP_DIV, OP_DIVU: state_d = div_valid ? ST_FIX : ST_DIV;
            OP_MTHI: begin
              hi_d   = req_src1;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = req_src1;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mul_cnt_q == MUL_LAST) begin
          state_d      = ST_IDLE;
          {hi_d, lo_d} = product;
          done_d       = 1'b1;
        end
      end
      ST_DIV: begin
        if (flush) state_d = ST_IDLE;
        else if (div_valid) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          hi_d   = div_rem;
          lo_d   = div_quo;
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // HI/LO, done pulse and multiplier operand/latency registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q         <= '0;
      lo_q         <= '0;
      done_q       <= 1'b0;
      mul_cnt_q    <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_signed_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      if (accept) begin
        mul_a_q      <= req_src1;
        mul_b_q      <= req_src2;
        mul_signed_q <= (req_op == OP_MULT);
        mul_cnt_q    <= 3'd1;
      end else if (state_q == ST_MUL) begin
        mul_cnt_q <= mul_cnt_q + 3'd1;
      end
    end
  end

endmodule
